// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: one shared prescaler produces a tick at TICK_HZ,
// and each channel runs independently as OFF, ON, BLINK or ONESHOT.

// Per-channel mode/period/count state machine with registered outputs.
module led_blinker_chan #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                wr_i,
    input  logic [1:0]          mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                signal_o,
    output logic                done_o
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    mode_e               mode_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count_q;
    logic                signal_q;
    logic                done_q;

    // A period of 0 behaves like 1 so the count compare always terminates.
    logic [PERIOD_W-1:0] period_wr;
    assign period_wr = (period_i == '0) ? PERIOD_W'(1) : period_i;

    // Channel state: a write wins over a tick in the same cycle; done is a
    // single-cycle pulse raised together with the ONESHOT falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            period_q <= PERIOD_W'(1);
            count_q  <= '0;
            signal_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (wr_i) begin
            mode_q   <= mode_e'(mode_i);
            period_q <= period_wr;
            count_q  <= '0;
            signal_q <= (mode_i != MODE_OFF);
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick_i) begin
                case (mode_q)
                    MODE_BLINK: begin
                        if (count_q == period_q - 1'b1) begin
                            signal_q <= ~signal_q;
                            count_q  <= '0;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (count_q == period_q - 1'b1) begin
                            signal_q <= 1'b0;
                            mode_q   <= MODE_OFF;
                            count_q  <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    default: ; // OFF/ON hold; count stays 0
                endcase
            end
        end
    end

    assign signal_o = signal_q;
    assign done_o   = done_q;
endmodule

module led_blinker_multi #(
    parameter  int FREQ     = 50_000_000,
    parameter  int TICK_HZ  = 1000,
    parameter  int CH       = 4,
    parameter  int PERIOD_W = 16,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic [CH-1:0]       signal,
    output logic [CH-1:0]       done
);
    localparam int DIV   = FREQ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] presc_q;
    logic             tick;

    // With DIV=1 the counter is stuck at 0 == PRE_MAX, so tick follows enable.
    assign tick = enable && (presc_q == PRE_MAX);

    // Free-running prescaler; frozen by enable, never disturbed by writes.
    always_ff @(posedge clk) begin
        if (!rst_n)
            presc_q <= '0;
        else if (enable)
            presc_q <= (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic wr_sel;
        // Out-of-range channel numbers never match any instance.
        assign wr_sel = cfg_we && (cfg_ch == CH_W'(g));

        led_blinker_chan #(.PERIOD_W(PERIOD_W)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (tick),
            .wr_i     (wr_sel),
            .mode_i   (cfg_mode),
            .period_i (cfg_period),
            .signal_o (signal[g]),
            .done_o   (done[g])
        );
    end
endmodule

// File: tb/tb_led_blinker_multi.sv
// Bench: two DUTs (DIV=1 and DIV=10) driven by the same inputs, compared each
// cycle against a ticks-since-write model, plus directed constant checks.
module tb_led_blinker_multi;
    localparam int CH = 3;
    localparam int PW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, enable, cfg_we;
    logic [1:0]    cfg_ch, cfg_mode;
    logic [PW-1:0] cfg_period;
    logic [CH-1:0] sig_f, done_f, sig_s, done_s;

    led_blinker_multi #(.FREQ(4), .TICK_HZ(4), .CH(CH), .PERIOD_W(PW)) u_fast (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .signal(sig_f), .done(done_f)
    );

    led_blinker_multi #(.FREQ(20), .TICK_HZ(2), .CH(CH), .PERIOD_W(PW)) u_slow (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .signal(sig_s), .done(done_s)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode, period and ticks elapsed since the last write.
    int            div [2] = '{1, 10};
    int            pcnt[2];
    int            m   [2][CH];
    int            p   [2][CH];
    int            t   [2][CH];
    logic [CH-1:0] edone[2];

    function automatic logic [CH-1:0] esig(int d);
        logic [CH-1:0] s;
        s = '0;
        for (int c = 0; c < CH; c++) begin
            case (m[d][c])
                1:       s[c] = 1'b1;
                2:       s[c] = ((t[d][c] / p[d][c]) % 2) == 0;
                3:       s[c] = 1'b1;
                default: s[c] = 1'b0;
            endcase
        end
        return s;
    endfunction

    task automatic model_edge();
        bit tick;
        for (int d = 0; d < 2; d++) begin
            tick = enable && (pcnt[d] == div[d] - 1);
            if (!rst_n) begin
                pcnt[d]  = 0;
                edone[d] = '0;
                for (int c = 0; c < CH; c++) begin
                    m[d][c] = 0; p[d][c] = 1; t[d][c] = 0;
                end
            end else begin
                if (enable) pcnt[d] = (pcnt[d] + 1) % div[d];
                for (int c = 0; c < CH; c++) begin
                    edone[d][c] = 1'b0;
                    if (cfg_we && int'(cfg_ch) == c) begin
                        m[d][c] = int'(cfg_mode);
                        p[d][c] = (cfg_period == 0) ? 1 : int'(cfg_period);
                        t[d][c] = 0;
                    end else if (tick && m[d][c] >= 2) begin
                        t[d][c]++;
                        if (m[d][c] == 3 && t[d][c] == p[d][c]) begin
                            m[d][c] = 0;
                            t[d][c] = 0;
                            edone[d][c] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare both DUTs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("sig_fast",  32'(sig_f),  32'(esig(0)));
        chk("done_fast", 32'(done_f), 32'(edone[0]));
        chk("sig_slow",  32'(sig_s),  32'(esig(1)));
        chk("done_slow", 32'(done_s), 32'(edone[1]));
    endtask

    task automatic wr(int ch, int mode, int per);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = PW'(per);
    endtask

    // Steps until slow ch2 changes; a timeout leaves n=200 which fails the caller.
    task automatic wait_toggle(output int n);
        logic prev;
        prev = sig_s[2];
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (sig_s[2] !== prev) return;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b1;
        wr(0, 1, 4);

        // Reset overrides a pending write and enable
        repeat (3) step();
        chk("rst_sig_f",  32'(sig_f),  0);
        chk("rst_done_f", 32'(done_f), 0);
        chk("rst_sig_s",  32'(sig_s),  0);
        chk("rst_presc",  32'(u_slow.presc_q), 0);
        rst_n = 1'b1; cfg_we = 1'b0;
        step();
        chk("post_rst_sig", 32'(sig_f), 0);

        // BLINK ch1 period 3 at DIV=1
        wr(1, 2, 3);
        step();
        cfg_we = 1'b0;
        chk("blink_e0", 32'(sig_f[1]), 1);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("blink_seq", 32'(sig_f[1]), 32'(((k / 3) % 2) == 0));
            chk("blink_others", 32'({sig_f[2], sig_f[0]}), 0);
        end

        // ONESHOT ch0 period 5 at DIV=1
        wr(0, 3, 5);
        step();
        cfg_we = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("oneshot_sig",  32'(sig_f[0]),  32'(k < 5));
            chk("oneshot_done", 32'(done_f[0]), 32'(k == 5));
        end

        // Prescaler interval and enable freeze on the DIV=10 instance
        wr(2, 2, 2);
        step();
        cfg_we = 1'b0;
        wait_toggle(n);
        wait_toggle(n);
        chk("blink_interval", 32'(n), 20);
        wait_toggle(n);
        chk("blink_interval2", 32'(n), 20);
        repeat (5) step();
        enable = 1'b0;
        repeat (7) step();
        enable = 1'b1;
        wait_toggle(n);
        chk("enable_delay", 32'(n + 12), 27);

        // Override a running blink on ch2 with ON, then period 0 BLINK
        wr(2, 1, 9);
        step();
        cfg_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("override_on", 32'(sig_f[2]), 1);
        end
        wr(2, 2, 0);
        step();
        cfg_we = 1'b0;
        chk("p0_start", 32'(sig_f[2]), 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("p0_toggle", 32'(sig_f[2]), 32'((k % 2) == 0));
        end

        // Write landing on the ONESHOT expiry tick suppresses done
        wr(0, 3, 3);
        step();
        cfg_we = 1'b0;
        repeat (2) step();
        wr(0, 0, 1);
        step();
        chk("collide_sig",  32'(sig_f[0]),  0);
        chk("collide_done", 32'(done_f[0]), 0);
        cfg_we = 1'b0;
        step();
        chk("collide_done2", 32'(done_f[0]), 0);

        // Out-of-range channel is ignored
        wr(3, 1, 7);
        step();
        cfg_we = 1'b0;
        chk("bad_ch", 32'(sig_f[0]), 0);

        // Randomized traffic, including resets mid-blink/oneshot
        for (int i = 0; i < 800; i++) begin
            rst_n      = ($urandom % 80) != 0;
            enable     = ($urandom % 8) != 0;
            cfg_we     = ($urandom % 6) == 0;
            cfg_ch     = 2'($urandom % 4);
            cfg_mode   = 2'($urandom % 4);
            cfg_period = PW'($urandom % 5);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
